// File: rtl/alarm_trigger.sv
// rtl/alarm_trigger.sv - alarm ring decision: trigger on time match, stop, snooze, ring timeout
//
// Ports:
//   clk, reset               system clock, synchronous active-high reset
//   c_hour1..c_min0          running clock time (BCD digits)
//   sec_tick                 one-cycle pulse per second
//   a_hour1..a_min0          stored alarm time (BCD digits)
//   AL_ON                    alarm enable (level)
//   STOP_al                  stop request (level)
//   SNOOZE                   snooze request (level)
//   Alarm                    ringing indicator (registered)
//   snoozing                 snooze delay running (registered)

module alarm_trigger #(
    parameter int RING_TIMEOUT_S = 60,
    parameter int SNOOZE_MIN     = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] c_hour1,
    input  logic [3:0] c_hour0,
    input  logic [3:0] c_min1,
    input  logic [3:0] c_min0,
    input  logic       sec_tick,
    input  logic [1:0] a_hour1,
    input  logic [3:0] a_hour0,
    input  logic [3:0] a_min1,
    input  logic [3:0] a_min0,
    input  logic       AL_ON,
    input  logic       STOP_al,
    input  logic       SNOOZE,
    output logic       Alarm,
    output logic       snoozing
);

    localparam int SNZ_TICKS = SNOOZE_MIN * 60;
    localparam int RING_W    = $clog2(RING_TIMEOUT_S) + 1;
    localparam int SNZ_W     = $clog2(SNZ_TICKS) + 1;

    localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_TIMEOUT_S - 1);
    localparam logic [SNZ_W-1:0]  SNZ_LAST  = SNZ_W'(SNZ_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RINGING = 2'd1,
        S_SNOOZE  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [RING_W-1:0]  ring_cnt;
    logic [RING_W-1:0]  ring_cnt_next;
    logic [SNZ_W-1:0]   snz_cnt;
    logic [SNZ_W-1:0]   snz_cnt_next;
    logic               match;
    logic               match_q;
    logic               trigger;

    assign match = (c_hour1 == a_hour1) && (c_hour0 == a_hour0) &&
                   (c_min1  == a_min1)  && (c_min0  == a_min0);

    // Only the rising edge of match rings, so a minute that stays matched
    // rings at most once. match_q resets to 1 so 00:00 right after reset
    // (or enabling while already matched) does not ring.
    assign trigger = match && !match_q && AL_ON;

    always_comb begin
        state_next    = state;
        ring_cnt_next = ring_cnt;
        snz_cnt_next  = snz_cnt;

        unique case (state)
            S_IDLE: begin
                if (trigger) begin
                    state_next    = S_RINGING;
                    ring_cnt_next = '0;
                end
            end

            S_RINGING: begin
                if (!AL_ON) begin
                    state_next = S_IDLE;
                end else if (STOP_al) begin
                    // Stop outranks snooze when both are pressed together.
                    state_next = S_IDLE;
                end else if (SNOOZE) begin
                    state_next   = S_SNOOZE;
                    snz_cnt_next = '0;
                end else if (sec_tick) begin
                    if (ring_cnt == RING_LAST) begin
                        state_next = S_IDLE;
                    end else begin
                        ring_cnt_next = ring_cnt + RING_W'(1);
                    end
                end
            end

            S_SNOOZE: begin
                // A held SNOOZE and fresh time matches are both ignored here.
                if (!AL_ON || STOP_al) begin
                    state_next = S_IDLE;
                end else if (sec_tick) begin
                    if (snz_cnt == SNZ_LAST) begin
                        state_next    = S_RINGING;
                        ring_cnt_next = '0;
                    end else begin
                        snz_cnt_next = snz_cnt + SNZ_W'(1);
                    end
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            ring_cnt <= '0;
            snz_cnt  <= '0;
            match_q  <= 1'b1;
            Alarm    <= 1'b0;
            snoozing <= 1'b0;
        end else begin
            state    <= state_next;
            ring_cnt <= ring_cnt_next;
            snz_cnt  <= snz_cnt_next;
            match_q  <= match;
            Alarm    <= (state_next == S_RINGING);
            snoozing <= (state_next == S_SNOOZE);
        end
    end

endmodule

// File: tb/tb_alarm_trigger.sv
// tb/tb_alarm_trigger.sv - self-checking bench for alarm_trigger

module tb_alarm_trigger;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] c_hour1;
    logic [3:0] c_hour0;
    logic [3:0] c_min1;
    logic [3:0] c_min0;
    logic       sec_tick;
    logic [1:0] a_hour1;
    logic [3:0] a_hour0;
    logic [3:0] a_min1;
    logic [3:0] a_min0;
    logic       AL_ON;
    logic       STOP_al;
    logic       SNOOZE;
    logic       Alarm;
    logic       snoozing;

    int         checks = 0;
    int         errors = 0;
    logic [1:0] exp_q[$];
    logic [1:0] got;

    alarm_trigger #(
        .RING_TIMEOUT_S(3),
        .SNOOZE_MIN    (1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .c_hour1  (c_hour1),
        .c_hour0  (c_hour0),
        .c_min1   (c_min1),
        .c_min0   (c_min0),
        .sec_tick (sec_tick),
        .a_hour1  (a_hour1),
        .a_hour0  (a_hour0),
        .a_min1   (a_min1),
        .a_min0   (a_min0),
        .AL_ON    (AL_ON),
        .STOP_al  (STOP_al),
        .SNOOZE   (SNOOZE),
        .Alarm    (Alarm),
        .snoozing (snoozing)
    );

    always #5 clk = ~clk;

    task automatic set_c(input logic [1:0] h1, input logic [3:0] h0,
                         input logic [3:0] m1, input logic [3:0] m0);
        c_hour1 = h1; c_hour0 = h0; c_min1 = m1; c_min0 = m0;
    endtask

    // Queue the expected {Alarm, snoozing} for the edge about to happen, then
    // advance past that edge so the registered outputs can be sampled.
    task automatic cycle(input logic [1:0] expected);
        exp_q.push_back(expected);
        @(posedge clk);
        #1;
    endtask

    task automatic ring_from_idle();
        set_c(2'd0, 4'd7, 4'd3, 4'd1);
        cycle(2'b00); void'(exp_q.pop_front());
        set_c(2'd0, 4'd7, 4'd3, 4'd0);
        cycle(2'b10); void'(exp_q.pop_front());
    endtask

    task automatic test_reset();
        reset = 1'b1; sec_tick = 0; AL_ON = 1; STOP_al = 0; SNOOZE = 0;
        a_hour1 = 2'd0; a_hour0 = 4'd7; a_min1 = 4'd3; a_min0 = 4'd0;
        set_c(2'd0, 4'd0, 4'd0, 4'd0);
        cycle(2'b00); void'(exp_q.pop_front());
        cycle(2'b00); got = exp_q.pop_front();
        checks++;
        if ({Alarm, snoozing} !== got) begin
            errors++; $display("FAIL reset_state: got=%b exp=%b", {Alarm, snoozing}, got);
        end
        reset = 1'b0;
    endtask

    task automatic test_trigger();
        set_c(2'd0, 4'd7, 4'd2, 4'd9);
        cycle(2'b00); got = exp_q.pop_front();
        checks++;
        if ({Alarm, snoozing} !== got) begin
            errors++; $display("FAIL pre_match: got=%b exp=%b", {Alarm, snoozing}, got);
        end
        set_c(2'd0, 4'd7, 4'd3, 4'd0);
        cycle(2'b10); got = exp_q.pop_front();
        checks++;
        if ({Alarm, snoozing} !== got) begin
            errors++; $display("FAIL ring_start: got=%b exp=%b", {Alarm, snoozing}, got);
        end
        for (int i = 0; i < 5; i++) begin
            cycle(2'b10); got = exp_q.pop_front();
            checks++;
            if ({Alarm, snoozing} !== got) begin
                errors++; $display("FAIL ring_hold[%0d]: got=%b exp=%b", i, {Alarm, snoozing}, got);
            end
        end
    endtask

    task automatic test_stop();
        STOP_al = 1'b1;
        cycle(2'b00); got = exp_q.pop_front();
        checks++;
        if ({Alarm, snoozing} !== got) begin
            errors++; $display("FAIL stop: got=%b exp=%b", {Alarm, snoozing}, got);
        end
        STOP_al = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle(2'b00); got = exp_q.pop_front();
            checks++;
            if ({Alarm, snoozing} !== got) begin
                errors++; $display("FAIL no_rering[%0d]: got=%b exp=%b", i, {Alarm, snoozing}, got);
            end
        end
        set_c(2'd0, 4'd7, 4'd3, 4'd1);
        cycle(2'b00); got = exp_q.pop_front();
        checks++;
        if ({Alarm, snoozing} !== got) begin
            errors++; $display("FAIL leave_match: got=%b exp=%b", {Alarm, snoozing}, got);
        end
        set_c(2'd0, 4'd7, 4'd3, 4'd0);
        cycle(2'b10); got = exp_q.pop_front();
        checks++;
        if ({Alarm, snoozing} !== got) begin
            errors++; $display("FAIL rering: got=%b exp=%b", {Alarm, snoozing}, got);
        end
    endtask

    // Ringing with RING_TIMEOUT_S=3: drops on the edge that samples the 3rd tick.
    task automatic test_timeout();
        logic [1:0] tick_exp [3];
        tick_exp[0] = 2'b10; tick_exp[1] = 2'b10; tick_exp[2] = 2'b00;
        for (int i = 0; i < 3; i++) begin
            sec_tick = 1'b1;
            cycle(tick_exp[i]); got = exp_q.pop_front();
            checks++;
            if ({Alarm, snoozing} !== got) begin
                errors++; $display("FAIL timeout_tick%0d: got=%b exp=%b", i + 1, {Alarm, snoozing}, got);
            end
            sec_tick = 1'b0;
            cycle(tick_exp[i]); void'(exp_q.pop_front());
        end
    endtask

    task automatic test_snooze();
        ring_from_idle();
        SNOOZE = 1'b1;
        cycle(2'b01); got = exp_q.pop_front();
        checks++;
        if ({Alarm, snoozing} !== got) begin
            errors++; $display("FAIL snooze_enter: got=%b exp=%b", {Alarm, snoozing}, got);
        end
        // SNOOZE still held, plus a fresh match edge: both ignored while snoozing.
        set_c(2'd0, 4'd7, 4'd3, 4'd1);
        cycle(2'b01); void'(exp_q.pop_front());
        set_c(2'd0, 4'd7, 4'd3, 4'd0);
        cycle(2'b01); got = exp_q.pop_front();
        checks++;
        if ({Alarm, snoozing} !== got) begin
            errors++; $display("FAIL snooze_ignore: got=%b exp=%b", {Alarm, snoozing}, got);
        end
        SNOOZE = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            sec_tick = 1'b1;
            cycle((i == 60) ? 2'b10 : 2'b01); got = exp_q.pop_front();
            if (i == 59 || i == 60) begin
                checks++;
                if ({Alarm, snoozing} !== got) begin
                    errors++; $display("FAIL snooze_tick%0d: got=%b exp=%b", i, {Alarm, snoozing}, got);
                end
            end
            sec_tick = 1'b0;
            cycle((i == 60) ? 2'b10 : 2'b01); void'(exp_q.pop_front());
        end
    endtask

    task automatic test_stop_and_snooze();
        STOP_al = 1'b1; SNOOZE = 1'b1;
        cycle(2'b00); got = exp_q.pop_front();
        checks++;
        if ({Alarm, snoozing} !== got) begin
            errors++; $display("FAIL stop_beats_snooze: got=%b exp=%b", {Alarm, snoozing}, got);
        end
        STOP_al = 1'b0; SNOOZE = 1'b0;
        cycle(2'b00); void'(exp_q.pop_front());
    endtask

    task automatic test_enable();
        ring_from_idle();
        SNOOZE = 1'b1;
        cycle(2'b01); void'(exp_q.pop_front());
        SNOOZE = 1'b0;
        AL_ON = 1'b0;
        cycle(2'b00); got = exp_q.pop_front();
        checks++;
        if ({Alarm, snoozing} !== got) begin
            errors++; $display("FAIL al_off_snooze: got=%b exp=%b", {Alarm, snoozing}, got);
        end
        AL_ON = 1'b1;
        cycle(2'b00); got = exp_q.pop_front();
        checks++;
        if ({Alarm, snoozing} !== got) begin
            errors++; $display("FAIL enable_while_match: got=%b exp=%b", {Alarm, snoozing}, got);
        end
        AL_ON = 1'b0;
        set_c(2'd0, 4'd7, 4'd3, 4'd1);
        cycle(2'b00); void'(exp_q.pop_front());
        set_c(2'd0, 4'd7, 4'd3, 4'd0);
        cycle(2'b00); got = exp_q.pop_front();
        checks++;
        if ({Alarm, snoozing} !== got) begin
            errors++; $display("FAIL disabled_block: got=%b exp=%b", {Alarm, snoozing}, got);
        end
        AL_ON = 1'b1;
    endtask

    task automatic test_alarm_change_mid_ring();
        ring_from_idle();
        a_min0 = 4'd5;
        cycle(2'b10); got = exp_q.pop_front();
        checks++;
        if ({Alarm, snoozing} !== got) begin
            errors++; $display("FAIL a_change_ring: got=%b exp=%b", {Alarm, snoozing}, got);
        end
        a_min0 = 4'd0;
    endtask

    task automatic test_reset_mid_ring();
        reset = 1'b1;
        cycle(2'b00); got = exp_q.pop_front();
        checks++;
        if ({Alarm, snoozing} !== got) begin
            errors++; $display("FAIL reset_mid_ring: got=%b exp=%b", {Alarm, snoozing}, got);
        end
        a_hour0 = 4'd0; a_min1 = 4'd0; a_min0 = 4'd0;
        set_c(2'd0, 4'd0, 4'd0, 4'd0);
        cycle(2'b00); void'(exp_q.pop_front());
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle(2'b00); got = exp_q.pop_front();
            checks++;
            if ({Alarm, snoozing} !== got) begin
                errors++; $display("FAIL midnight_after_reset[%0d]: got=%b exp=%b", i, {Alarm, snoozing}, got);
            end
        end
    endtask

    initial begin
        test_reset();
        test_trigger();
        test_stop();
        test_timeout();
        test_snooze();
        test_stop_and_snooze();
        test_enable();
        test_alarm_change_mid_ring();
        test_reset_mid_ring();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
